// File: rtl/fft_pkg.sv
// Shared definitions for the FFT twiddle complex-multiply scheduler:
// FSM states, product-select encodings and default widths.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fft_state_e;

  // Partial-product order; the same code, delayed one cycle, selects the accumulate op.
  localparam logic [1:0] SEL_RR = 2'd0;  // xr*wr -> acc_re +
  localparam logic [1:0] SEL_II = 2'd1;  // xi*wi -> acc_re -
  localparam logic [1:0] SEL_RI = 2'd2;  // xr*wi -> acc_im +
  localparam logic [1:0] SEL_IR = 2'd3;  // xi*wr -> acc_im +

  localparam int FFT_W     = 16;
  localparam int FFT_OUT_W = 17;
  localparam int FFT_SHIFT = 15;

endpackage

// File: rtl/fft_cmul_sched_if.sv
// Operand/result bus of the complex-multiply scheduler.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready;
// the source holds its payload and valid until then, and ready never depends on valid.
interface fft_cmul_sched_if #(
  parameter int W     = 16,
  parameter int OUT_W = 17
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     xr;
  logic signed [W-1:0]     xi;
  logic signed [W-1:0]     wr;
  logic signed [W-1:0]     wi;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] yr;
  logic signed [OUT_W-1:0] yi;
  logic                    sat;

  modport master (
    output in_valid, xr, xi, wr, wi, out_ready,
    input  in_ready, out_valid, yr, yi, sat
  );

  modport slave (
    input  in_valid, xr, xi, wr, wi, out_ready,
    output in_ready, out_valid, yr, yi, sat
  );
endinterface

// File: rtl/fft_cmul_mult.sv
// Registered signed W x W multiplier: partial products reduced by levels of
// 3:2 compressors (Wallace tree), one final carry-propagate add, one cycle latency.
module fft_cmul_mult #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);
  localparam int PW   = 2 * W;
  localparam int IW   = $clog2(W + 2);
  localparam int LVLS = 10;

  logic [PW-1:0] sum;

  always_comb begin : tree
    logic [PW-1:0] a_ext;
    logic [PW-1:0] rows [0:W];
    logic [PW-1:0] nxt  [0:W];
    logic [PW-1:0] x, y, z;
    logic [IW-1:0] m;
    int            n;

    a_ext = {{W{a[W-1]}}, a};
    // The sign bit of b has negative weight: add ~(a<<(W-1)) plus a separate +1 row.
    for (int i = 0; i < W; i++) begin
      if (i < W - 1) rows[i] = b[i] ? (a_ext << i) : '0;
      else           rows[i] = b[i] ? ~(a_ext << i) : '0;
    end
    rows[W] = PW'(b[W-1]);
    n = W + 1;
    m = '0;
    x = '0;
    y = '0;
    z = '0;

    for (int lvl = 0; lvl < LVLS; lvl++) begin
      if (n > 2) begin
        for (int g = 0; g <= W; g++) nxt[g] = '0;
        m = '0;
        for (int g = 0; g < (W + 1) / 3; g++) begin
          if (3 * g + 2 < n) begin
            x = rows[3*g];
            y = rows[3*g+1];
            z = rows[3*g+2];
            nxt[m]        = x ^ y ^ z;
            nxt[m + 1'b1] = ((x & y) | (x & z) | (y & z)) << 1;
            m = m + 2'd2;
          end
        end
        for (int r = 0; r <= W; r++) begin
          if (r >= 3 * (n / 3) && r < n) begin
            nxt[m] = rows[r];
            m = m + 1'b1;
          end
        end
        for (int r = 0; r <= W; r++) rows[r] = nxt[r];
        n = int'(m);
      end
    end

    sum = rows[0] + rows[1];
  end

  always_ff @(posedge clk) begin
    if (rst)     p <= '0;
    else if (en) p <= sum;
  end

endmodule

// File: rtl/fft_cmul_sched.sv
// Complex multiply (xr + j*xi)*(wr + j*wi) on one shared multiplier, scaled by SHIFT and
// saturated to OUT_W bits. Define FFT_CMUL_ROUND_EN for round-half-up instead of floor.
module fft_cmul_sched
  import fft_pkg::*;
#(
  parameter int W     = FFT_W,
  parameter int OUT_W = FFT_OUT_W,
  parameter int SHIFT = FFT_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_cmul_sched_if.slave         bus,
  output fft_state_e              state_dbg
);
  localparam int ACC_W = 2 * W + 1;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));
`ifdef FFT_CMUL_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'sd1 <<< (SHIFT - 1));
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  fft_state_e             state;
  logic [1:0]             cnt;
  logic signed [W-1:0]    xr_q, xi_q, wr_q, wi_q;
  logic signed [W-1:0]    op_a, op_b;
  logic signed [2*W-1:0]  prod;
  logic                   tag_v;
  logic [1:0]             tag_q;
  logic signed [ACC_W-1:0] acc_re, acc_im, acc_re_nx, acc_im_nx, p_ext;
  logic signed [ACC_W-1:0] sc_re, sc_im;
  logic signed [OUT_W-1:0] yr_nx, yi_nx;
  logic                   sat_nx;
  logic                   out_valid_q;
  logic signed [OUT_W-1:0] yr_q, yi_q;
  logic                   sat_q;

  always_comb begin
    op_a = xr_q;
    op_b = wr_q;
    case (cnt)
      SEL_II: begin op_a = xi_q; op_b = wi_q; end
      SEL_RI: begin op_a = xr_q; op_b = wi_q; end
      SEL_IR: begin op_a = xi_q; op_b = wr_q; end
      default: ;
    endcase
  end

  fft_cmul_mult #(.W(W)) u_mult (
    .clk (clk),
    .rst (rst),
    .en  (state == MUL),
    .a   (op_a),
    .b   (op_b),
    .p   (prod)
  );

  // Accumulators as they stand after this edge; DRAIN converts from these directly.
  always_comb begin
    p_ext     = {prod[2*W-1], prod};
    acc_re_nx = acc_re;
    acc_im_nx = acc_im;
    if (tag_v) begin
      case (tag_q)
        SEL_RR:  acc_re_nx = acc_re + p_ext;
        SEL_II:  acc_re_nx = acc_re - p_ext;
        default: acc_im_nx = acc_im + p_ext;
      endcase
    end
  end

  always_comb begin
    sc_re  = (acc_re_nx + RND) >>> SHIFT;
    sc_im  = (acc_im_nx + RND) >>> SHIFT;
    yr_nx  = (sc_re > Y_MAX) ? Y_MAX[OUT_W-1:0] :
             (sc_re < Y_MIN) ? Y_MIN[OUT_W-1:0] : sc_re[OUT_W-1:0];
    yi_nx  = (sc_im > Y_MAX) ? Y_MAX[OUT_W-1:0] :
             (sc_im < Y_MIN) ? Y_MIN[OUT_W-1:0] : sc_im[OUT_W-1:0];
    sat_nx = (sc_re > Y_MAX) || (sc_re < Y_MIN) || (sc_im > Y_MAX) || (sc_im < Y_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      xr_q        <= '0;
      xi_q        <= '0;
      wr_q        <= '0;
      wi_q        <= '0;
      tag_v       <= 1'b0;
      tag_q       <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      out_valid_q <= 1'b0;
      yr_q        <= '0;
      yi_q        <= '0;
      sat_q       <= 1'b0;
    end else begin
      tag_v  <= (state == MUL);
      tag_q  <= cnt;
      acc_re <= acc_re_nx;
      acc_im <= acc_im_nx;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr_q   <= bus.xr;
            xi_q   <= bus.xi;
            wr_q   <= bus.wr;
            wi_q   <= bus.wi;
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DRAIN;
        end
        DRAIN: begin
          yr_q        <= yr_nx;
          yi_q        <= yi_nx;
          sat_q       <= sat_nx;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.yr        = yr_q;
  assign bus.yi        = yi_q;
  assign bus.sat       = sat_q;
  assign state_dbg     = state;

endmodule
